// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared encodings for the instruction fetch stage
package fetch_unit_pkg;

    // Fetch FSM state encodings (2 bits)
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } fetch_state_t;

    // Bubble word latched by IF/ID when no real instruction is available
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Hazard-unit level meaning "PC may advance"
    localparam logic        PC_WRITE_ON = 1'b1;

    // Force a redirect target onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC register, next-PC mux and fetch FSM
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        if_flush,
    output logic        addr_error
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_q, hold_d;
    logic [31:0]  pend_q, pend_d;
    logic         addr_error_q, addr_error_d;

    logic [31:0]  tgt;
    logic [31:0]  pc_plus4;
    logic [31:0]  pend_next;

    assign tgt       = align_word(redirect_target);
    assign pc_plus4  = pc_q + 32'd4;
    // A redirect arriving while discarding replaces the pending target
    assign pend_next = redirect_valid ? tgt : pend_q;

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign addr_error = addr_error_q;

    // Output decode: data passes straight through from memory, bubbles otherwise
    always_comb begin
        imem_req    = 1'b0;
        instruction = NOP_INSTR;
        fetch_valid = 1'b0;
        if_flush    = 1'b0;
        if (!reset) begin
            if_flush = redirect_valid;
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        instruction = imem_rdata;
                        fetch_valid = 1'b1;
                    end
                end
                S_DISCARD: begin
                    imem_req = 1'b1;
                end
                S_HOLD: begin
                    instruction = hold_q;
                    fetch_valid = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic: redirect beats stall beats advance
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        pend_d       = pend_q;
        addr_error_d = addr_error_q;

        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            addr_error_d = 1'b1;
        end

        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        // Request must stay stable until ready, so park the target
                        pend_d  = tgt;
                        state_d = S_DISCARD;
                    end
                end else if (imem_ready && (pc_write == PC_WRITE_ON)) begin
                    pc_d = pc_plus4;
                end else if (imem_ready) begin
                    hold_d  = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (imem_ready) begin
                    pc_d    = pend_next;
                    state_d = S_FETCH;
                end else begin
                    pend_d = pend_next;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = tgt;
                    state_d = S_FETCH;
                end else if (pc_write == PC_WRITE_ON) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_q       <= 32'h0;
            pend_q       <= 32'h0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            addr_error_q <= addr_error_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        if_flush;
    logic        addr_error;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_write        (pc_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .if_flush        (if_flush),
        .addr_error      (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after the edge; outputs are sampled 2 units later
    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rd, input logic pw,
                         input logic rv, input logic [31:0] rt);
        imem_ready      = rdy;
        imem_rdata      = rd;
        pc_write        = pw;
        redirect_valid  = rv;
        redirect_target = rt;
        settle();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        // Outputs forced quiet while reset is high
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_instr", instruction,          32'h0);
        check("rst_flush", {31'b0, if_flush},    32'h0);
        tick();
        check("rst_pc",    pc,                   32'h0);
        check("rst_aerr",  {31'b0, addr_error},  32'h0);
        reset = 1'b0;

        // Streaming fetch with memory always ready
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000_0000 + i, 1'b1, 1'b0, 32'h0);
            check("stream_addr",  imem_addr,            32'(i * 4));
            check("stream_valid", {31'b0, fetch_valid}, 32'h1);
            check("stream_instr", instruction,          32'h1000_0000 + i);
            tick();
        end

        // Wait states at pc=0x10
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
            check("wait_valid", {31'b0, fetch_valid}, 32'h0);
            check("wait_instr", instruction,          32'h0);
            check("wait_addr",  imem_addr,            32'h10);
            check("wait_req",   {31'b0, imem_req},    32'h1);
            tick();
        end
        drive(1'b1, 32'h2402_0005, 1'b1, 1'b0, 32'h0);
        check("wait_done_instr", instruction, 32'h2402_0005);
        check("wait_done_pc",    pc,          32'h10);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wait_next_addr", imem_addr, 32'h14);

        // Advance 0x14 -> 0x20
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
            tick();
        end

        // Hazard stall at pc=0x20
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
        check("stall_addr",  imem_addr,   32'h20);
        check("stall_instr", instruction, 32'hAAAA_0001);
        tick();
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        check("hold_req",   {31'b0, imem_req},    32'h0);
        check("hold_instr", instruction,          32'hAAAA_0001);
        check("hold_valid", {31'b0, fetch_valid}, 32'h1);
        check("hold_pc",    pc,                   32'h20);
        tick();
        drive(1'b0, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
        check("hold_rel_instr", instruction, 32'hAAAA_0001);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("hold_next_addr", imem_addr,        32'h24);
        check("hold_next_req",  {31'b0, imem_req}, 32'h1);

        // Advance 0x24 -> 0x40
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
            tick();
        end

        // Redirect while request outstanding
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100);
        check("redir_addr",  imem_addr,            32'h40);
        check("redir_flush", {31'b0, if_flush},    32'h1);
        check("redir_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("disc_req",   {31'b0, imem_req}, 32'h1);
        check("disc_addr",  imem_addr,         32'h40);
        check("disc_flush", {31'b0, if_flush}, 32'h0);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        check("disc_drop_valid", {31'b0, fetch_valid}, 32'h0);
        check("disc_drop_instr", instruction,          32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("disc_next_addr", imem_addr, 32'h100);

        // Misaligned redirect, then PC wrap
        drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
        check("mis_flush", {31'b0, if_flush}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("mis_pc",   pc,                  32'h100);
        check("mis_aerr", {31'b0, addr_error}, 32'h1);
        drive(1'b1, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wrap_pre_pc", pc,                  32'hFFFF_FFFC);
        check("aerr_sticky", {31'b0, addr_error}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);

        // Reset while in HOLD (pc=8)
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
        check("pre_hold_pc", pc, 32'h8);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("in_hold_req", {31'b0, imem_req}, 32'h0);
        reset = 1'b1;
        settle();
        check("rst_hold_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_hold_instr", instruction,          32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("post_hold_pc",    pc,                   32'h0);
        check("post_hold_aerr",  {31'b0, addr_error},  32'h0);
        check("post_hold_req",   {31'b0, imem_req},    32'h1);
        check("post_hold_valid", {31'b0, fetch_valid}, 32'h0);

        // Reset while in DISCARD (pc=4, pending 0x200)
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
        tick();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("rst_disc_req", {31'b0, imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h0000_0099, 1'b1, 1'b0, 32'h0);
        check("post_disc_addr",  imem_addr,            32'h0);
        check("post_disc_valid", {31'b0, fetch_valid}, 32'h1);
        check("post_disc_instr", instruction,          32'h0000_0099);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("post_disc_next", imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage pipeline.
- Owns the PC register and drives the instruction-memory request.
- Presents {instruction, pc} to the IF/ID pipeline register, which computes pc+4 itself.
- Absorbs memory wait states, hazard-unit stalls and ID-stage branch/jump redirects; emits NOP (32'h0) whenever no valid instruction is available, so IF/ID latches a bubble.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk only
pc_write  input  1  hazard unit: 1 = PC may advance, 0 = stall
redirect_valid  input  1  ID stage: taken branch / j / jal / jr resolved this cycle
redirect_target  input  32  new PC for redirect
imem_req  output  1  instruction-memory request
imem_addr  output  32  word address of request
imem_ready  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ready
instruction  output  32  to IF/ID; 32'h0 when fetch_valid=0
pc  output  32  PC of the presented instruction
fetch_valid  output  1  instruction is real (not bubble)
if_flush  output  1  redirect accepted this cycle; hazard unit ORs into IF/ID flush
addr_error  output  1  sticky: misaligned redirect target seen

Behaviour:
- Single clock. Reset is synchronous and active-high, on ports named clk and reset.
- Registers: pc_r, state, hold_r[31:0], pend_r[31:0], addr_error_r.
- States: S_FETCH, S_DISCARD, S_HOLD.
- Reset (sync): pc_r=RESET_PC, state=S_FETCH, hold_r=0, pend_r=0, addr_error_r=0.
- While reset is high, outputs are forced to: imem_req=0, instruction=0, fetch_valid=0, if_flush=0.
- Aligned target: tgt = {redirect_target[31:2],2'b00}. If redirect_target[1:0]!=0, set addr_error_r=1; it clears only on reset.
- pc output = pc_r in every state. imem_addr = pc_r.
- S_FETCH:
  - imem_req=1. The request (addr) is held stable until imem_ready.
  - ready=1: instruction=imem_rdata, fetch_valid=1 (combinational, zero added latency).
  - redirect_valid=1: if_flush=1.
    - If ready: pc_r<=tgt, stay in S_FETCH.
    - If !ready: pend_r<=tgt, go to S_DISCARD.
  - Else ready & pc_write: pc_r<=pc_r+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Else ready & !pc_write: hold_r<=imem_rdata, go to S_HOLD.
  - Else (!ready): stay, fetch_valid=0.
- S_DISCARD:
  - imem_req=1, addr unchanged, fetch_valid=0.
  - On ready: data dropped, pc_r<=pend_r, go to S_FETCH.
  - A further redirect overwrites pend_r and asserts if_flush.
- S_HOLD:
  - imem_req=0, instruction=hold_r, fetch_valid=1.
  - redirect_valid: if_flush=1, pc_r<=tgt, go to S_FETCH.
  - Else pc_write=1: pc_r<=pc_r+4, go to S_FETCH.
  - Else stay.
- Priority every cycle: reset > redirect > stall > advance.
- Reset mid-request abandons the outstanding request. The memory must tolerate imem_req dropping without ready.
- Redirect wins over pc_write=0. The redirect-producing branch is already in ID, so the stall does not block it.

Decomposition:
- Shared ctrl_encode_def additions:
  - state encodings FETCH_S_FETCH/DISCARD/HOLD (2 bits)
  - `NOP_INSTR 32'h0
  - `PC_WRITE_ON
- No sub-module: PC register, next-PC mux and FSM stay in one module, about 150 lines.

Test Plan:
- Reset, imem_ready tied 1, pc_write=1, 4 cycles -> imem_addr = 0,4,8,C; fetch_valid=1; instruction follows imem_rdata.
- pc_r=0x10, imem_ready low 3 cycles then high with 0x2402_0005 -> fetch_valid=0, instruction=0 for 3 cycles; then 0x2402_0005 presented with pc=0x10; next addr 0x14.
- Ready=1, pc_write=0 for 2 cycles at pc=0x20, rdata=0xAAAA_0001 -> S_HOLD, imem_req=0, instruction held 0xAAAA_0001; after release addr=0x24.
- Redirect to 0x100 at pc=0x40 while imem_ready=0, ready arrives 2 cycles later with 0xDEAD_BEEF -> if_flush=1 in redirect cycle; data discarded (fetch_valid=0); next imem_addr=0x100.
- Redirect target 0x0000_0102 -> pc=0x100, addr_error=1 and stays 1 until reset; pc=0xFFFF_FFFC with ready -> next pc=0x0.
- Reset asserted in S_HOLD and in S_DISCARD -> next cycle state=S_FETCH, pc=RESET_PC, addr_error=0, no stale instruction presented.
